// File: rtl/hash_macro_regif.sv
// Macro-side register responder: debounces level-style bus writes into one-shot commits,
// holds job bytes, and queues found nonces. Define HASH_REGIF_READBACK_EN to read job bytes back.
module hash_macro_regif #(
    parameter int JOB_BYTES     = 48,
    parameter int FIFO_DEPTH    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                   M1_CLK,
    input  logic                   RST_M1_N,
    input  logic                   HASH_EN,
    input  logic                   WR_SELECT,
    input  logic                   RD_SELECT,
    input  logic [5:0]             HASH_ADDR,
    input  logic [7:0]             DATA_TO_HASH,
    output logic [7:0]             DATA_FROM_HASH,
    output logic                   DATA_AVAILABLE,
    output logic [8*JOB_BYTES-1:0] job_data,
    output logic                   hash_start,
    output logic                   hash_run,
    input  logic                   nonce_valid,
    input  logic [31:0]            nonce_in
);

    localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0] CNT_FIRE = 3'(STABLE_CYCLES - 1);
    localparam logic [3:0] DEPTH_C  = 4'(FIFO_DEPTH);

    logic [14:0]   bus_q, bus_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          committed_q, committed_d;
    logic [7:0]    job_q [JOB_BYTES];
    logic [7:0]    job_d [JOB_BYTES];
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          avail_q, avail_d;
    logic          run_q, run_d;
    logic          start_q, start_d;
    logic          same, commit, pop, push, full, empty;
    logic [31:0]   head;

    assign bus_d = {WR_SELECT, HASH_ADDR, DATA_TO_HASH};

    // A write commits once the same bus tuple has been seen for STABLE_CYCLES edges.
    always_comb begin
        same        = (bus_d == bus_q);
        cnt_d       = same ? ((cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1) : 3'd0;
        commit      = WR_SELECT && same && (cnt_q == CNT_FIRE) && !committed_q;
        committed_d = committed_q;
        if (!WR_SELECT || !same)
            committed_d = 1'b0;
        else if (commit)
            committed_d = 1'b1;
    end

    always_comb begin
        empty    = (count_q == 4'd0);
        full     = (count_q == DEPTH_C);
        pop      = commit && (HASH_ADDR == 6'h3F) && !empty;
        push     = nonce_valid && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = nonce_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        // A dropped push outranks a same-cycle clear so no overflow is ever lost.
        ovf_d = ovf_q;
        if (commit && (HASH_ADDR == 6'h38) && DATA_TO_HASH[7])
            ovf_d = 1'b0;
        if (nonce_valid && full && !pop)
            ovf_d = 1'b1;
        head = mem_q[rd_ptr_q];
    end

    always_comb begin
        job_d = job_q;
        for (int i = 0; i < JOB_BYTES; i++)
            if (commit && (HASH_ADDR == 6'(i)))
                job_d[i] = DATA_TO_HASH;
    end

    always_comb begin
        rdata_d = 8'h00;
        if (RD_SELECT) begin
            if (HASH_ADDR == 6'h38) begin
                rdata_d = {ovf_q, 3'b000, count_q};
            end else if ((HASH_ADDR[5:2] == 4'hF) && !empty) begin
                case (HASH_ADDR[1:0])
                    2'd0:    rdata_d = head[7:0];
                    2'd1:    rdata_d = head[15:8];
                    2'd2:    rdata_d = head[23:16];
                    default: rdata_d = head[31:24];
                endcase
            end
`ifdef HASH_REGIF_READBACK_EN
            for (int i = 0; i < JOB_BYTES; i++)
                if (HASH_ADDR == 6'(i))
                    rdata_d = job_q[i];
`endif
        end
        avail_d = (count_q != 4'd0);
        run_d   = HASH_EN;
        start_d = HASH_EN & ~run_q;
    end

    always_ff @(posedge M1_CLK or negedge RST_M1_N) begin
        if (!RST_M1_N) begin
            bus_q       <= '0;
            cnt_q       <= '0;
            committed_q <= 1'b0;
            for (int i = 0; i < JOB_BYTES; i++)
                job_q[i] <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            rdata_q     <= 8'h00;
            avail_q     <= 1'b0;
            run_q       <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            bus_q       <= bus_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            job_q       <= job_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            rdata_q     <= rdata_d;
            avail_q     <= avail_d;
            run_q       <= run_d;
            start_q     <= start_d;
        end
    end

    // Entry storage is qualified by count/pointers, so it needs no reset.
    always_ff @(posedge M1_CLK)
        mem_q <= mem_d;

    for (genvar g = 0; g < JOB_BYTES; g++) begin : g_job
        assign job_data[8*g +: 8] = job_q[g];
    end

    assign DATA_FROM_HASH = rdata_q;
    assign DATA_AVAILABLE = avail_q;
    assign hash_start     = start_q;
    assign hash_run       = run_q;

endmodule

// File: tb/tb_hash_macro_regif.sv
// Scoreboard bench for hash_macro_regif: random bus traffic against a queue/array reference model.
module tb_hash_macro_regif;

    localparam int JB = 48;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            hash_en = 1'b0;
    logic            wr_sel = 1'b0;
    logic            rd_sel = 1'b0;
    logic [5:0]      addr = 6'd0;
    logic [7:0]      wdata = 8'd0;
    logic [7:0]      rdata;
    logic            avail;
    logic [8*JB-1:0] job_data;
    logic            hash_start;
    logic            hash_run;
    logic            nonce_valid = 1'b0;
    logic [31:0]     nonce_in = 32'd0;

    hash_macro_regif #(.JOB_BYTES(JB), .FIFO_DEPTH(FD), .STABLE_CYCLES(3)) dut (
        .M1_CLK(clk), .RST_M1_N(rst_n), .HASH_EN(hash_en), .WR_SELECT(wr_sel),
        .RD_SELECT(rd_sel), .HASH_ADDR(addr), .DATA_TO_HASH(wdata),
        .DATA_FROM_HASH(rdata), .DATA_AVAILABLE(avail), .job_data(job_data),
        .hash_start(hash_start), .hash_run(hash_run),
        .nonce_valid(nonce_valid), .nonce_in(nonce_in)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  m_job [JB];
    logic [31:0] m_fifo [$];
    logic        m_ovf = 1'b0;
    logic [7:0]  exp_q [$];
    int          exp_a [$];
    logic        rd_vld = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_job(input string nm);
        logic [8*JB-1:0] e;
        for (int i = 0; i < JB; i++) e[8*i +: 8] = m_job[i];
        n_tests++;
        if (job_data !== e) begin
            n_fail++;
            $display("FAIL %s: job_data got %h expected %h", nm, job_data, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_read(input int a);
        logic [31:0] h;
        if (a < JB) begin
`ifdef HASH_REGIF_READBACK_EN
            return m_job[a];
`else
            return 8'h00;
`endif
        end
        if (a == 56) return {m_ovf, 3'b000, 4'(m_fifo.size())};
        if (a >= 60) begin
            if (m_fifo.size() == 0) return 8'h00;
            h = m_fifo[0];
            return 8'(h >> (8 * (a - 60)));
        end
        return 8'h00;
    endfunction

    function automatic void m_commit(input int a, input logic [7:0] d);
        if (a < JB) m_job[a] = d;
        else if (a == 56 && d[7]) m_ovf = 1'b0;
        else if (a == 63 && m_fifo.size() > 0) void'(m_fifo.pop_front());
    endfunction

    function automatic void m_push(input logic [31:0] n);
        if (m_fifo.size() < FD) m_fifo.push_back(n);
        else m_ovf = 1'b1;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < JB; i++) m_job[i] = 8'h00;
        m_fifo.delete();
        m_ovf = 1'b0;
    endfunction

    // Hold a write for 'hold' edges; optionally push a nonce in the cycle the commit lands.
    task automatic wr(input int a, input logic [7:0] d, input int hold,
                      input bit do_push, input logic [31:0] n);
        wr_sel = 1'b1; addr = 6'(a); wdata = d;
        for (int i = 1; i <= hold; i++) begin
            if (do_push && i == 4) begin nonce_valid = 1'b1; nonce_in = n; end
            tick();
            nonce_valid = 1'b0;
        end
        wr_sel = 1'b0;
        tick(); tick();
        if (hold >= 4) m_commit(a, d);
        if (do_push) m_push(n);
    endtask

    task automatic push(input logic [31:0] n);
        nonce_valid = 1'b1; nonce_in = n;
        tick();
        nonce_valid = 1'b0;
        tick(); tick();
        m_push(n);
    endtask

    task automatic rd(input int a);
        rd_sel = 1'b1; addr = 6'(a);
        exp_q.push_back(m_read(a));
        exp_a.push_back(a);
        tick();
        rd_sel = 1'b0;
        tick();
        chk("rd_deselected", 32'(rdata), 32'h0);
    endtask

    always @(posedge clk) rd_vld <= rd_sel;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                chk("read_unexpected", 32'(rdata), 32'hFFFF_FFFF);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                automatic int         a = exp_a.pop_front();
                chk($sformatf("read@%02h", a), 32'(rdata), 32'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        m_reset();
        #2;
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_avail", 32'(avail), 32'h0);
        chk("rst_start", 32'(hash_start), 32'h0);
        chk("rst_run", 32'(hash_run), 32'h0);
        chk_job("rst_job");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Held write: not committed early, committed after the stability window.
        wr_sel = 1'b1; addr = 6'h05; wdata = 8'hA5;
        tick(); tick();
        chk("wr_not_early", 32'(job_data[47:40]), 32'h0);
        tick(); tick();
        chk("wr_committed", 32'(job_data[47:40]), 32'hA5);
        repeat (6) tick();
        wr_sel = 1'b0;
        tick(); tick();
        m_commit(5, 8'hA5);
        chk_job("job_after_wr");

        // Data changes after one cycle: only the later value commits.
        wr_sel = 1'b1; addr = 6'h06; wdata = 8'hA5;
        tick();
        wdata = 8'h5A;
        tick();
        chk("toggle_no_commit", 32'(job_data[55:48]), 32'h0);
        repeat (5) tick();
        chk("toggle_commit", 32'(job_data[55:48]), 32'h5A);
        wr_sel = 1'b0;
        tick(); tick();
        m_commit(6, 8'h5A);

        rd(5);
        rd(56);

        push(32'h1122_3344);
        push(32'hAABB_CCDD);
        chk("avail_after_push", 32'(avail), 32'h1);
        for (int a = 60; a < 64; a++) rd(a);
        wr(63, 8'h00, 10, 1'b0, 32'h0);
        rd(56);
        for (int a = 60; a < 64; a++) rd(a);
        wr(63, 8'h00, 10, 1'b0, 32'h0);
        chk("avail_after_pop", 32'(avail), 32'h0);
        rd(56);
        rd(60);

        for (int i = 0; i < 5; i++) push(32'hC0DE_0000 + 32'(i));
        rd(56);
        rd(60);
        wr(56, 8'h80, 5, 1'b0, 32'h0);
        rd(56);
        wr(63, 8'h00, 6, 1'b1, 32'h5555_AAAA);
        rd(56);
        for (int a = 60; a < 64; a++) rd(a);
        repeat (4) wr(63, 8'h00, 5, 1'b0, 32'h0);
        rd(56);
        wr(63, 8'h00, 6, 1'b1, 32'h0BAD_F00D);
        rd(56);
        rd(63);

        hash_en = 1'b1;
        tick();
        chk("start_pulse", 32'(hash_start), 32'h1);
        chk("run_high", 32'(hash_run), 32'h1);
        pulses = 0;
        repeat (4) begin tick(); pulses += int'(hash_start); end
        chk("start_once", 32'(pulses), 32'h0);
        hash_en = 1'b0;
        tick();
        chk("run_low", 32'(hash_run), 32'h0);
        chk_job("job_after_en_fall");
        rd(56);

        for (int op = 0; op < 300; op++) begin
            case ($urandom_range(0, 9))
                0, 1: wr($urandom_range(0, JB - 1), 8'($urandom),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(4, 8),
                         1'b0, 32'h0);
                2: push($urandom);
                3: wr(63, 8'($urandom), $urandom_range(4, 8), 1'($urandom_range(0, 1)), $urandom);
                4: wr(56, 8'($urandom), $urandom_range(4, 8), 1'b0, 32'h0);
                5: wr($urandom_range(48, 63), 8'($urandom), $urandom_range(4, 8), 1'b0, 32'h0);
                6, 7: rd($urandom_range(0, 63));
                8: begin
                    chk("avail_rand", 32'(avail), 32'(m_fifo.size() != 0));
                    chk_job("job_rand");
                end
                default: begin
                    hash_en = ~hash_en;
                    tick();
                    chk("run_rand", 32'(hash_run), 32'(hash_en));
                    chk("start_rand", 32'(hash_start), 32'(hash_en));
                    tick();
                    chk("start_rand_end", 32'(hash_start), 32'h0);
                end
            endcase
        end

        // Asynchronous reset in the middle of activity with two queued nonces.
        hash_en = 1'b0;
        while (m_fifo.size() > 0) wr(63, 8'h00, 5, 1'b0, 32'h0);
        push(32'h0102_0304);
        push(32'h0506_0708);
        hash_en = 1'b1;
        rd_sel = 1'b1; addr = 6'h38;
        exp_q.push_back(m_read(56));
        exp_a.push_back(56);
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        rd_sel = 1'b0;
        hash_en = 1'b0;
        #1;
        m_reset();
        chk("midrst_rdata", 32'(rdata), 32'h0);
        chk("midrst_avail", 32'(avail), 32'h0);
        chk("midrst_run", 32'(hash_run), 32'h0);
        chk("midrst_start", 32'(hash_start), 32'h0);
        chk_job("midrst_job");
        @(negedge clk) rst_n = 1'b1;
        tick();
        rd(56);
        chk("postrst_avail", 32'(avail), 32'h0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
